// File: rtl/uart_txrx.sv
`default_nettype none
// ============================================================================
// Module   : uart_txrx
// Brief    : Single-clock UART transceiver, independent TX and RX paths,
//            8N1 frames; optional even parity when UART_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_txrx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_txd,
    output logic       o_tx_busy,
    input  logic       i_rxd,
    output logic [7:0] o_data,
    output logic       o_rx_valid,
    output logic       o_rx_err
);

`ifdef UART_PARITY_EN
    localparam logic c_PAR_EN = 1'b1;
`else
    localparam logic c_PAR_EN = 1'b0;
`endif

    localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] c_HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    logic [2:0]  tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_par_q, tx_par_d;
    logic        txd_q, txd_d;
    logic        tx_load;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        txd_d      = txd_q;
        tx_load    = 1'b0;
        if (tx_state_q == c_ST_IDLE) begin
            tx_cnt_d = 16'd0;
            tx_load  = i_start;
        end else if (tx_cnt_q != c_BIT_LAST) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end else begin
            tx_cnt_d = 16'd0;
            case (tx_state_q)
                c_ST_START: begin
                    tx_state_d = c_ST_DATA;
                    tx_idx_d   = 3'd0;
                    txd_d      = tx_shift_q[0];
                end
                c_ST_DATA: begin
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                        txd_d      = c_PAR_EN ? tx_par_q : 1'b1;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_idx_d   = tx_idx_q + 3'd1;
                        txd_d      = tx_shift_q[1];
                    end
                end
                c_ST_PARITY: begin
                    tx_state_d = c_ST_STOP;
                    txd_d      = 1'b1;
                end
                c_ST_STOP: begin
                    // A held request chains the next start bit with no idle gap
                    tx_load    = i_start;
                    tx_state_d = c_ST_IDLE;
                    txd_d      = 1'b1;
                end
                default: begin
                    tx_state_d = c_ST_IDLE;
                    txd_d      = 1'b1;
                end
            endcase
        end
        if (tx_load) begin
            tx_state_d = c_ST_START;
            tx_cnt_d   = 16'd0;
            tx_shift_d = i_data;
            tx_par_d   = ^i_data;
            txd_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            tx_state_q <= c_ST_IDLE;
            tx_cnt_q   <= 16'd0;
            tx_idx_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_par_q   <= 1'b0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            txd_q      <= txd_d;
        end
    end

    assign o_txd     = txd_q;
    assign o_tx_busy = (tx_state_q != c_ST_IDLE);

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0]  rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_par_ok_q, rx_par_ok_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_err_q, rx_err_d;
    logic        rx_fall;

    // Edge-triggered start detection keeps a held-low line from re-arming
    assign rx_fall = rx_prev_q & ~rx_sync_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_idx_d    = rx_idx_q;
        rx_shift_d  = rx_shift_q;
        rx_par_ok_d = rx_par_ok_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_err_d    = 1'b0;
        case (rx_state_q)
            c_ST_IDLE: begin
                rx_cnt_d = 16'd0;
                if (rx_fall) begin
                    rx_state_d = c_ST_START;
                end
            end
            c_ST_START: begin
                if (rx_cnt_q == c_HALF_LAST) begin
                    rx_cnt_d    = 16'd0;
                    rx_idx_d    = 3'd0;
                    rx_par_ok_d = 1'b1;
                    rx_state_d  = rx_sync_q ? c_ST_IDLE : c_ST_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: begin
                if (rx_cnt_q != c_BIT_LAST) begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end else begin
                    rx_cnt_d = 16'd0;
                    if (rx_state_q == c_ST_DATA) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_idx_d   = rx_idx_q + 3'd1;
                        if (rx_idx_q == 3'd7) begin
                            rx_state_d = c_PAR_EN ? c_ST_PARITY : c_ST_STOP;
                        end
                    end else if (rx_state_q == c_ST_PARITY) begin
                        rx_par_ok_d = (rx_sync_q == ^rx_shift_q);
                        rx_state_d  = c_ST_STOP;
                    end else begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = rx_sync_q & rx_par_ok_q;
                        rx_err_d   = ~(rx_sync_q & rx_par_ok_q);
                        rx_state_d = c_ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= c_ST_IDLE;
            rx_cnt_q    <= 16'd0;
            rx_idx_q    <= 3'd0;
            rx_shift_q  <= 8'h00;
            rx_par_ok_q <= 1'b1;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            rx_meta_q   <= i_rxd;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_idx_q    <= rx_idx_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_ok_q <= rx_par_ok_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign o_data     = rx_data_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_err   = rx_err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_txrx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_txrx
// Brief    : Self-checking bench for uart_txrx (loopback, manual RX frames,
//            parity cases when UART_PARITY_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_txrx;

    localparam int N = 16;
`ifdef UART_PARITY_EN
    localparam int B = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int B = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       txd, busy, rx_valid, rx_err;
    logic [7:0] dout;
    logic       loop_en = 1'b1;
    logic       rxd_drv = 1'b1;
    logic       rxd_line;

    assign rxd_line = loop_en ? txd : rxd_drv;

    uart_txrx #(.CLKS_PER_BIT(N)) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_start    (start),
        .i_data     (din),
        .o_txd      (txd),
        .o_tx_busy  (busy),
        .i_rxd      (rxd_line),
        .o_data     (dout),
        .o_rx_valid (rx_valid),
        .o_rx_err   (rx_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int err_cnt = 0;
    int viol = 0;
    logic prev_v = 1'b0;
    logic prev_e = 1'b0;
    logic [7:0] vq[$];
    int         vcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                vq.push_back(dout);
                vcyc.push_back(cyc);
            end
            if (rx_err) err_cnt++;
            if (rx_valid && rx_err) viol++;
            if ((rx_valid && prev_v) || (rx_err && prev_e)) viol++;
        end
        prev_v = rx_valid;
        prev_e = rx_err;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit ones_parity(input logic [7:0] d);
        int n = 0;
        for (int i = 0; i < 8; i++) n += (d >> i) & 1;
        return bit'(n % 2);
    endfunction

    // Frame position k: 0 start, 1..8 data LSB first, optional parity, stop last
    function automatic logic frame_bit(input logic [7:0] d, input logic p, input logic s, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return logic'((d >> (k - 1)) & 1);
        if (PAR && k == 9) return p;
        return s;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic p, input logic [7:0] exp_rx);
        int e0;
        vq.delete();
        vcyc.delete();
        e0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        din = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        din = ~d;
        chk("tx_latency_busy", busy, 1);
        chk("tx_latency_start", txd, 0);
        for (int k = 0; k < B; k++) begin
            repeat ((k == 0) ? N / 2 : N) @(posedge clk);
            #1;
            chk("tx_bit", txd, frame_bit(d, p, 1'b1, k));
        end
        repeat (N / 2 - 1) @(posedge clk);
        #1;
        chk("tx_busy_last_cycle", busy, 1);
        @(posedge clk);
        #1;
        chk("tx_busy_end", busy, 0);
        chk("tx_idle_high", txd, 1);
        chk("rx_valid_count", vq.size(), 1);
        if (vq.size() > 0) chk("rx_data", vq.pop_front(), exp_rx);
        chk("rx_no_err", err_cnt - e0, 0);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        for (int k = 0; k < B; k++) begin
            @(negedge clk);
            rxd_drv = frame_bit(d, p, s, k);
            repeat (N - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        repeat (2 * N) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int e0;
        logic [7:0] d;
        tbl[0] = '{8'h56, 1'b0, 8'h56};
        tbl[1] = '{8'hA5, 1'b0, 8'hA5};
        tbl[2] = '{8'h07, 1'b1, 8'h07};
        tbl[3] = '{8'h3C, 1'b0, 8'h3C};
        tbl[4] = '{8'h00, 1'b0, 8'h00};
        tbl[5] = '{8'hFF, 1'b0, 8'hFF};
        tbl[6] = '{8'h01, 1'b1, 8'h01};
        tbl[7] = '{8'h80, 1'b1, 8'h80};
        tbl[8] = '{8'h7F, 1'b1, 8'h7F};

        repeat (4) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_busy", busy, 0);
        chk("rst_data", dout, 8'h00);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err", rx_err, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++) send_frame(tbl[i].data, tbl[i].par, tbl[i].exp_rx);

        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_frame(d, ones_parity(d), d);
        end

        // Back-to-back frames with i_start held high
        vq.delete();
        vcyc.delete();
        @(negedge clk);
        start = 1'b1;
        din = 8'hA5;
        @(posedge clk);
        #1;
        for (int f = 0; f < 3; f++) begin
            chk("b2b_start_bit", txd, 0);
            chk("b2b_busy", busy, 1);
            if (f == 2) start = 1'b0;
            for (int k = 0; k < B; k++) begin
                repeat ((k == 0) ? N / 2 : N) @(posedge clk);
                #1;
                chk("b2b_bit", txd, frame_bit(8'hA5, 1'b0, 1'b1, k));
                chk("b2b_busy_mid", busy, 1);
            end
            repeat (N / 2) @(posedge clk);
            #1;
        end
        chk("b2b_busy_end", busy, 0);
        repeat (2 * N) @(negedge clk);
        chk("b2b_rx_count", vq.size(), 3);
        for (int i = 0; i < vq.size(); i++) chk("b2b_rx_data", vq[i], 8'hA5);
        for (int i = 1; i < vcyc.size(); i++) chk("b2b_rx_spacing", vcyc[i] - vcyc[i-1], B * N);

        // Manual RX drive from here
        loop_en = 1'b0;
        rxd_drv = 1'b1;
        vq.delete();
        e0 = err_cnt;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (3 * N) @(negedge clk);
        chk("glitch_no_valid", vq.size(), 0);
        chk("glitch_no_err", err_cnt - e0, 0);

        e0 = err_cnt;
        drive_frame(8'h3C, 1'b0, 1'b0);
        chk("stop0_err", err_cnt - e0, 1);
        chk("stop0_no_valid", vq.size(), 0);
        chk("stop0_data", dout, 8'h3C);

`ifdef UART_PARITY_EN
        e0 = err_cnt;
        drive_frame(8'h07, 1'b0, 1'b1);
        chk("par_bad_err", err_cnt - e0, 1);
        chk("par_bad_no_valid", vq.size(), 0);
        chk("par_bad_data", dout, 8'h07);
        drive_frame(8'h07, 1'b1, 1'b1);
        chk("par_good_err", err_cnt - e0, 1);
        chk("par_good_valid", vq.size(), 1);
        if (vq.size() > 0) chk("par_good_data", vq.pop_front(), 8'h07);
`endif

        // Break: line held low for many bit times
        e0 = err_cnt;
        @(negedge clk);
        rxd_drv = 1'b0;
        repeat (3 * B * N) @(negedge clk);
        chk("break_one_err", err_cnt - e0, 1);
        chk("break_no_valid", vq.size(), 0);
        rxd_drv = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("break_release_no_err", err_cnt - e0, 1);
        drive_frame(8'h5A, ones_parity(8'h5A), 1'b1);
        chk("after_break_valid", vq.size(), 1);
        if (vq.size() > 0) chk("after_break_data", vq.pop_front(), 8'h5A);
        chk("after_break_no_err", err_cnt - e0, 1);

        // Reset asserted mid-frame
        loop_en = 1'b1;
        vq.delete();
        @(negedge clk);
        start = 1'b1;
        din = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (3 * N) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", dout, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        e0 = err_cnt;
        repeat (12 * N) @(negedge clk);
        chk("midrst_txd_idle", txd, 1);
        chk("midrst_no_valid", vq.size(), 0);
        chk("midrst_no_err", err_cnt - e0, 0);

        chk("pulse_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_txrx.md
# uart_txrx

Single-clock UART transceiver holding a transmit path (uart_tx function) and a receive path (uart_rx function) in one block. TX serialises a byte onto `o_txd`; RX deserialises `i_rxd` back into a byte. Both paths share the same clock and bit-period counter parameter, so `o_txd` can be looped directly into `i_rxd` for self-test. The block sits between the system bus logic and the serial pins.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `i_clk` input 1: system clock; all logic on the rising edge.
- `i_reset` input 1: asynchronous, active-low reset.
- `i_start` input 1: transmit request, level-sensitive, sampled only while TX is idle.
- `i_data` input 8: byte to transmit, captured when a frame starts.
- `o_txd` output 1: serial output, idle high.
- `o_tx_busy` output 1: high while a TX frame is in progress.
- `i_rxd` input 1: serial input, asynchronous to `i_clk`.
- `o_data` output 8: last received byte.
- `o_rx_valid` output 1: one-cycle pulse when a good frame is received.
- `o_rx_err` output 1: one-cycle pulse on framing or parity error.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- TX FSM has the states IDLE, START, DATA, PARITY, STOP.
  - In IDLE, `i_start`=1 latches `i_data` into the shift register and moves to START.
  - Each state lasts CLKS_PER_BIT cycles. DATA runs 8 bit periods, shifting right.
  - After STOP the FSM returns to IDLE. If `i_start` is still high, the next frame starts on the next cycle, giving back-to-back frames with no extra idle bit.
  - Changes to `i_data` during a frame are ignored.
- RX front end: `i_rxd` passes through a 2-flop synchroniser.
- RX FSM has the states IDLE, START, DATA, PARITY, STOP.
  - In IDLE, a synchronised 1→0 transition enters START.
  - At CLKS_PER_BIT/2 (floor) into START the line is re-sampled. If it is 1, the event is a false start and the FSM returns to IDLE with no output.
  - After that, each bit is sampled every CLKS_PER_BIT cycles at mid-bit. Data bits shift in LSB first.
  - At the stop-bit sample, `o_data` is loaded with the shift register unconditionally.
  - If stop=1 and parity is OK, `o_rx_valid` pulses; otherwise `o_rx_err` pulses.
  - The FSM then returns to IDLE, which is able to detect a new start edge immediately.
- A line held low (break) produces `o_rx_err`. No new frame starts until the line returns to 1 and falls again.
- TX and RX are fully independent and may operate simultaneously.

## Timing
- Reset values: `o_txd`=1, `o_tx_busy`=0, `o_data`=8'h00, `o_rx_valid`=0, `o_rx_err`=0. Both FSMs go to IDLE and all counters clear.
- Asserting `i_reset` mid-frame aborts the frame immediately and `o_txd` goes to 1.
- TX latency: the start bit appears on `o_txd` on the edge after `i_start` is sampled high in IDLE, and `o_tx_busy` rises on that same edge.
- TX frame length: 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- `o_tx_busy` falls at the end of STOP only if no new frame starts.
- RX latency: the stop sample is taken 9×CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after the synchronised start edge, or 10×CLKS_PER_BIT + CLKS_PER_BIT/2 with parity. `o_data`, `o_rx_valid` and `o_rx_err` update on the following edge.
- `o_rx_valid` and `o_rx_err` are never high in the same cycle and each is exactly 1 cycle wide.
- The 2-flop synchroniser adds 2 cycles of input delay.

## Configuration
- `UART_PARITY_EN` defined:
  - TX inserts an even-parity bit (XOR of the 8 data bits) between data and stop.
  - RX checks the parity bit; a mismatch gives `o_rx_err` even if stop=1. `o_data` is still loaded.
- `UART_PARITY_EN` undefined: the PARITY states are never entered and frames are 10 bits.

## Test plan
- Reset: hold `i_reset`=0 → `o_txd`=1, `o_tx_busy`=0, `o_data`=0, no pulses. Then release.
- Loopback with `o_txd`→`i_rxd`, CLKS_PER_BIT=16, `i_data`=8'h56, 1-cycle `i_start` pulse:
  - `o_txd` shows bits 0,0,1,1,0,1,0,1,0,1, each lasting 16 cycles.
  - `o_data`=8'h56 and `o_rx_valid` pulses once.
- `i_start` held high, `i_data`=8'hA5:
  - Back-to-back frames with stop followed immediately by start, and `o_tx_busy` stays high.
  - RX reports 8'hA5 once per frame, 160 cycles apart.
- Glitch on `i_rxd` low for 3 cycles (N=16) → false start, no `o_rx_valid` and no `o_rx_err`.
- Frame 8'h3C sent with stop bit forced to 0 → `o_data`=8'h3C and `o_rx_err` pulses for one cycle, with no valid pulse.
- With `UART_PARITY_EN`, 8'h07 sent with a corrupted parity bit → `o_rx_err`. A correct frame (parity=1) → `o_rx_valid`.
